card_cursor_ctrl: RTL and testbench
===================================

Name: card_cursor_ctrl

Overview:
- Game-control stage upstream of the single-card painter on the 160x120, 3-bit-colour VGA path of the 3x3 card grid.
- Waits for the grid drawer to report a completed grid, then tracks a cursor over the 9 cards from push-button inputs.
- Reveals cards with a pseudo-random face colour.
- Issues one draw request per 16x16 card (base x/y plus colour) and waits for the painter's acknowledge.

Parameters:
- X_ORIGIN, 50, x of column-0 card's top-left pixel
- Y_ORIGIN, 30, y of row-0 card's top-left pixel
- PITCH, 20, pixel pitch between card origins (both axes)
- BLANK_COLOUR, 3'b111, face-down card colour
- CURSOR_COLOUR, 3'b100, highlight colour of card under cursor

Ports:
- clk  input  1  system clock, all logic on posedge
- reset_n  input  1  synchronous, active-low reset
- grid_ready  input  1  pulse/level from grid drawer: full grid painted
- key_up, key_down, key_left, key_right, key_select  input  1 each  active-high button levels
- draw_ack  input  1  one-cycle pulse from painter: requested card finished
- draw_req  output  1  card draw request, held until draw_ack
- draw_x0  output  8  card origin x
- draw_y0  output  7  card origin y
- draw_colour  output  3  fill colour for the card
- cursor_idx  output  4  current card index 0..8 (row*3+col)
- revealed  output  9  bit i set = card i revealed
- all_done  output  1  all 9 cards revealed

Behaviour:
- Reset (reset_n low at a posedge):
  - State goes to WAIT_GRID.
  - draw_req=0, draw_x0=X_ORIGIN, draw_y0=Y_ORIGIN, draw_colour=BLANK_COLOUR.
  - cursor_idx=0, revealed=0, all_done=0.
  - Face store cleared to BLANK_COLOUR, key history cleared, LFSR=8'h01.
  - Reset wins over every other event, including an outstanding draw_req; no ack is awaited.
- Key handling:
  - Each key is registered; edge = current & ~previous.
  - Edges are acted on only in IDLE; edges in other states are dropped.
  - Simultaneous edges use priority select > up > down > left > right; lower-priority edges are dropped.
- Coordinates:
  - col=idx%3, row=idx/3.
  - x0 = X_ORIGIN + PITCH*col and y0 = Y_ORIGIN + PITCH*row, computed in 8/7 bits; defaults give 50/70/90 and 30/50/70.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, steps every cycle out of reset.
  - face = lfsr[2:0], sampled in the select-edge cycle.
  - If face is 000, BLANK_COLOUR or CURSOR_COLOUR, 3'b010 is used instead.
- States:
  - WAIT_GRID: grid_ready=1 -> DRAW_CUR.
  - DRAW_CUR: request the cursor card in CURSOR_COLOUR; on draw_ack -> IDLE.
  - IDLE, move edge whose target differs from cursor_idx: latch old index, update cursor_idx -> ERASE.
  - IDLE, move edge whose target equals cursor_idx: no state change, no request.
  - IDLE, select edge on an unrevealed card: store face, set revealed bit -> REVEAL.
  - IDLE, select edge on a revealed card: ignored.
  - ERASE: request the old card in its stored face colour (BLANK_COLOUR if unrevealed); on ack -> DRAW_CUR.
  - REVEAL: request the cursor card in its face colour; on ack -> DONE if revealed==9'h1FF, else IDLE.
  - DONE: all_done=1; all keys ignored until reset.
- Request timing and handshake:
  - draw_req is registered and rises the cycle after the state entry decision.
  - A key first sampled high at edge N gives draw_req=1 after edge N+2.
  - draw_x0, draw_y0 and draw_colour are stable for the whole time draw_req is high.
  - On the cycle draw_ack is sampled high, draw_req drops at that edge and the state advances.
  - draw_ack while draw_req=0 is ignored.
- Moves:
  - up = idx-3, down = idx+3, left = idx-1 within the row, right = idx+1 within the row.
  - Edge behaviour at the grid border is set by the optional feature.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: moves past a grid edge wrap within the row/column. Left from col 0 goes to col 2; up from row 0 goes to row 2; the reverse directions wrap the same way.
- Undefined: moves past an edge saturate. The target equals the current index, so no state change and no draw request.

Test Plan:
- Reset, then grid_ready=1 for 1 cycle -> single draw_req with x0=50, y0=30, colour=100; ack -> IDLE, cursor_idx=0.
- From idx 0, press key_right -> request (50,30,111), then after ack (70,30,100); cursor_idx=1.
- From idx 0, press key_left -> with CURSOR_WRAP_EN: erase (50,30), draw (90,30,100), cursor_idx=2; without: no draw_req for 10 cycles, cursor_idx=0.
- At idx 4, press key_select -> request (70,50,face) with face not in {000,111,100} and equal to the bench LFSR model; revealed[4]=1. Second select -> no draw_req. Move away -> erase uses the same face colour.
- Reveal all 9 cards -> all_done=1 after the 9th ack; key presses then produce no draw_req.
- Assert reset_n=0 while draw_req=1 and draw_ack never comes -> after the next edge draw_req=0, revealed=0, cursor_idx=0; state is WAIT_GRID and ignores keys until grid_ready.

Source files
------------

// File: rtl/card_cursor_ctrl.sv
// card_cursor_ctrl
//   Game-control stage for the 3x3 card grid on the 160x120 VGA path. Waits
//   for the grid drawer, then moves a cursor over the nine 16x16 cards from
//   push-buttons, reveals cards with a pseudo-random face colour, and issues
//   one draw request per card to the single-card painter.
//
// Ports
//   clk           system clock (posedge)
//   reset_n       synchronous active-low reset
//   grid_ready    grid drawer has finished the full grid
//   key_*         active-high button levels (up/down/left/right/select)
//   draw_ack      one-cycle pulse from painter: requested card finished
//   draw_req      card draw request, held until draw_ack
//   draw_x0/y0    card origin, draw_colour fill colour
//   cursor_idx    current card index (row*3+col)
//   revealed      bit i set = card i revealed
//   all_done      all nine cards revealed
//
// Build option
//   CURSOR_WRAP_EN  defined: cursor moves wrap within the row/column;
//                   undefined: moves past a border saturate (no action).
module card_cursor_ctrl #(
  parameter int         X_ORIGIN      = 50,
  parameter int         Y_ORIGIN      = 30,
  parameter int         PITCH         = 20,
  parameter logic [2:0] BLANK_COLOUR  = 3'b111,
  parameter logic [2:0] CURSOR_COLOUR = 3'b100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       grid_ready,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_select,
  input  logic       draw_ack,
  output logic       draw_req,
  output logic [7:0] draw_x0,
  output logic [6:0] draw_y0,
  output logic [2:0] draw_colour,
  output logic [3:0] cursor_idx,
  output logic [8:0] revealed,
  output logic       all_done
);

  typedef enum logic [2:0] {WAIT_GRID, DRAW_CUR, IDLE, ERASE, REVEAL, DONE} state_t;

  state_t      state_q;
  logic [4:0]  key_q, key_prev_q;     // {select, up, down, left, right}
  logic [7:0]  lfsr_q;
  logic [2:0]  face_q [9];
  logic [3:0]  cursor_q, old_q;
  logic [8:0]  revealed_q;
  logic        draw_req_q, all_done_q;
  logic [7:0]  x0_q;
  logic [6:0]  y0_q;
  logic [2:0]  colour_q;

  logic [4:0]  edge_d;
  logic        sel_edge_d, move_edge_d;
  logic [1:0]  dir_d;
  logic [3:0]  target_d, req_idx_d;
  logic [2:0]  req_col_d, face_d;

  function automatic logic [1:0] col_of(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] row_of(input logic [3:0] idx);
    if (idx < 4'd3)      return 2'd0;
    else if (idx < 4'd6) return 2'd1;
    else                 return 2'd2;
  endfunction

  function automatic logic [7:0] x_of(input logic [3:0] idx);
    return 8'(X_ORIGIN + PITCH * int'(col_of(idx)));
  endfunction

  function automatic logic [6:0] y_of(input logic [3:0] idx);
    return 7'(Y_ORIGIN + PITCH * int'(row_of(idx)));
  endfunction

  // dir: 0 up, 1 down, 2 left, 3 right. At a border the target either wraps
  // or stays on the current card, which the FSM treats as "no move".
  function automatic logic [3:0] move_target(input logic [3:0] idx, input logic [1:0] dir);
    logic [1:0] c, r;
    c = col_of(idx);
    r = row_of(idx);
    case (dir)
`ifdef CURSOR_WRAP_EN
      2'd0:    return (r == 2'd0) ? idx + 4'd6 : idx - 4'd3;
      2'd1:    return (r == 2'd2) ? idx - 4'd6 : idx + 4'd3;
      2'd2:    return (c == 2'd0) ? idx + 4'd2 : idx - 4'd1;
      default: return (c == 2'd2) ? idx - 4'd2 : idx + 4'd1;
`else
      2'd0:    return (r == 2'd0) ? idx : idx - 4'd3;
      2'd1:    return (r == 2'd2) ? idx : idx + 4'd3;
      2'd2:    return (c == 2'd0) ? idx : idx - 4'd1;
      default: return (c == 2'd2) ? idx : idx + 4'd1;
`endif
    endcase
  endfunction

  // Faces that would be indistinguishable from a blank card, the cursor or
  // black are replaced with green.
  function automatic logic [2:0] fix_face(input logic [2:0] f);
    if (f == 3'b000 || f == BLANK_COLOUR || f == CURSOR_COLOUR) return 3'b010;
    return f;
  endfunction

  always_comb begin
    edge_d      = key_q & ~key_prev_q;
    sel_edge_d  = edge_d[4];
    move_edge_d = !edge_d[4] && (|edge_d[3:0]);
    if (edge_d[3])      dir_d = 2'd0;
    else if (edge_d[2]) dir_d = 2'd1;
    else if (edge_d[1]) dir_d = 2'd2;
    else                dir_d = 2'd3;
    target_d = move_target(cursor_q, dir_d);
    face_d   = fix_face(lfsr_q[2:0]);
    // Card and colour the current state wants painted.
    req_idx_d = cursor_q;
    req_col_d = CURSOR_COLOUR;
    if (state_q == ERASE) begin
      req_idx_d = old_q;
      req_col_d = face_q[old_q];
    end else if (state_q == REVEAL) begin
      req_col_d = face_q[cursor_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= WAIT_GRID;
      key_q       <= '0;
      key_prev_q  <= '0;
      lfsr_q      <= 8'h01;
      for (int i = 0; i < 9; i++) face_q[i] <= BLANK_COLOUR;
      cursor_q    <= '0;
      old_q       <= '0;
      revealed_q  <= '0;
      draw_req_q  <= 1'b0;
      all_done_q  <= 1'b0;
      x0_q        <= 8'(X_ORIGIN);
      y0_q        <= 7'(Y_ORIGIN);
      colour_q    <= BLANK_COLOUR;
    end else begin
      key_q      <= {key_select, key_up, key_down, key_left, key_right};
      key_prev_q <= key_q;
      lfsr_q     <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      case (state_q)
        WAIT_GRID: if (grid_ready) state_q <= DRAW_CUR;
        IDLE: begin
          if (sel_edge_d) begin
            if (!revealed_q[cursor_q]) begin
              face_q[cursor_q]     <= face_d;
              revealed_q[cursor_q] <= 1'b1;
              state_q              <= REVEAL;
            end
          end else if (move_edge_d && target_d != cursor_q) begin
            old_q    <= cursor_q;
            cursor_q <= target_d;
            state_q  <= ERASE;
          end
        end
        DRAW_CUR, ERASE, REVEAL: begin
          // Raise the request one cycle after entry; the payload is frozen
          // until the painter acknowledges.
          if (!draw_req_q) begin
            draw_req_q <= 1'b1;
            x0_q       <= x_of(req_idx_d);
            y0_q       <= y_of(req_idx_d);
            colour_q   <= req_col_d;
          end else if (draw_ack) begin
            draw_req_q <= 1'b0;
            if (state_q == ERASE) begin
              state_q <= DRAW_CUR;
            end else if (state_q == REVEAL && revealed_q == 9'h1FF) begin
              state_q    <= DONE;
              all_done_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign draw_req    = draw_req_q;
  assign draw_x0     = x0_q;
  assign draw_y0     = y0_q;
  assign draw_colour = colour_q;
  assign cursor_idx  = cursor_q;
  assign revealed    = revealed_q;
  assign all_done    = all_done_q;

endmodule

// File: tb/tb_card_cursor_ctrl.sv
module tb_card_cursor_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, grid_ready, draw_ack;
  logic [4:0] keys;   // {select, up, down, left, right}
  logic       draw_req, all_done;
  logic [7:0] draw_x0;
  logic [6:0] draw_y0;
  logic [2:0] draw_colour;
  logic [3:0] cursor_idx;
  logic [8:0] revealed;

  localparam logic [4:0] SEL = 5'b10000, UP = 5'b01000, DN = 5'b00100,
                         LF  = 5'b00010, RT = 5'b00001;

  int checks = 0, failures = 0;

  logic [7:0] lfsr_m;
  logic [7:0] lfsr_snap;
  logic [2:0] face_tb [9];
  logic [8:0] rev_tb;
  logic [2:0] last_col;

  always #5 clk = ~clk;

  card_cursor_ctrl dut (
    .clk(clk), .reset_n(reset_n), .grid_ready(grid_ready),
    .key_up(keys[3]), .key_down(keys[2]), .key_left(keys[1]),
    .key_right(keys[0]), .key_select(keys[4]), .draw_ack(draw_ack),
    .draw_req(draw_req), .draw_x0(draw_x0), .draw_y0(draw_y0),
    .draw_colour(draw_colour), .cursor_idx(cursor_idx),
    .revealed(revealed), .all_done(all_done)
  );

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed 01 on reset.
  always @(posedge clk) begin
    if (!reset_n) lfsr_m <= 8'h01;
    else          lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xof(input int i);
    return 8'(50 + 20 * (i % 3));
  endfunction

  function automatic logic [6:0] yof(input int i);
    return 7'(30 + 20 * (i / 3));
  endfunction

  function automatic logic [2:0] fixf(input logic [2:0] f);
    return (f == 3'b000 || f == 3'b111 || f == 3'b100) ? 3'b010 : f;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 9; i++) face_tb[i] = 3'b111;
    rev_tb = '0;
  endtask

  // One-cycle key press; lfsr_snap holds the LFSR value the DUT uses when it
  // acts on the edge one cycle later.
  task automatic press(input logic [4:0] k);
    keys = k;
    tick();
    lfsr_snap = lfsr_m;
    keys = '0;
  endtask

  task automatic expect_draw(input string tag, input logic [7:0] ex,
                             input logic [6:0] ey, input logic [2:0] ec);
    int n = 0;
    while (!draw_req && n < 20) begin tick(); n++; end
    if (!draw_req) begin
      check({tag, "_req_timeout"}, 0, 1);
      return;
    end
    last_col = draw_colour;
    check({tag, "_x"}, draw_x0, ex);
    check({tag, "_y"}, draw_y0, ey);
    check({tag, "_col"}, draw_colour, ec);
    tick();
    check({tag, "_held"}, {draw_req, draw_x0, draw_y0, draw_colour}, {1'b1, ex, ey, ec});
    draw_ack = 1'b1;
    tick();
    draw_ack = 1'b0;
    check({tag, "_dropped"}, draw_req, 0);
  endtask

  task automatic no_req(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin tick(); if (draw_req) seen = 1'b1; end
    check(tag, seen, 0);
  endtask

  task automatic move(input logic [4:0] k, input int from, input int to);
    press(k);
    expect_draw("erase", xof(from), yof(from), face_tb[from]);
    expect_draw("cursor", xof(to), yof(to), 3'b100);
    check("cursor_idx", cursor_idx, to);
  endtask

  task automatic reveal(input int idx);
    logic [2:0] fe;
    press(SEL);
    fe = fixf(lfsr_snap[2:0]);
    expect_draw("reveal", xof(idx), yof(idx), fe);
    check("face_legal", (last_col == 3'b000 || last_col == 3'b111 || last_col == 3'b100), 0);
    face_tb[idx] = fe;
    rev_tb[idx] = 1'b1;
    check("revealed", revealed, rev_tb);
  endtask

  task automatic grid_pulse();
    grid_ready = 1'b1;
    tick();
    grid_ready = 1'b0;
    expect_draw("grid", 8'd50, 7'd30, 3'b100);
    check("grid_cursor", cursor_idx, 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; grid_ready = 1'b0; draw_ack = 1'b0; keys = '0;
    clear_model();
    tick(); tick();
    check("rst_req", draw_req, 0);
    check("rst_x", draw_x0, 50);
    check("rst_y", draw_y0, 30);
    check("rst_col", draw_colour, 3'b111);
    check("rst_cursor", cursor_idx, 0);
    check("rst_revealed", revealed, 0);
    check("rst_done", all_done, 0);
    reset_n = 1'b1;

    press(RT);
    no_req("wait_grid_keys", 10);
    check("wait_grid_cursor", cursor_idx, 0);
    grid_pulse();

    // Request latency: key sampled at edge N, request visible after N+2.
    keys = RT; tick(); keys = '0;
    check("lat_n", draw_req, 0);
    tick();
    check("lat_n1", draw_req, 0);
    tick();
    check("lat_n2", draw_req, 1);
    expect_draw("erase", 8'd50, 7'd30, 3'b111);
    expect_draw("cursor", 8'd70, 7'd30, 3'b100);
    check("cursor_idx", cursor_idx, 1);
    move(LF, 1, 0);

`ifdef CURSOR_WRAP_EN
    move(LF, 0, 2);
    move(RT, 2, 0);
    move(UP, 0, 6);
    move(DN, 6, 0);
`else
    press(LF);
    no_req("left_sat", 10);
    check("left_sat_cursor", cursor_idx, 0);
    press(UP);
    no_req("up_sat", 10);
    check("up_sat_cursor", cursor_idx, 0);
`endif

    move(DN, 0, 3);
    move(RT, 3, 4);
    reveal(4);
    press(SEL);
    no_req("second_select", 10);
    check("second_select_rev", revealed, 9'h010);
    press(SEL | UP);
    no_req("sel_priority", 10);
    check("sel_priority_cursor", cursor_idx, 4);
    move(UP | LF, 4, 1);   // up wins; erase repaints card 4 in its face

    reveal(1); move(LF, 1, 0);
    reveal(0); move(DN, 0, 3);
    reveal(3); move(DN, 3, 6);
    reveal(6); move(RT, 6, 7);
    reveal(7); move(RT, 7, 8);
    reveal(8); move(UP, 8, 5);
    reveal(5); move(UP, 5, 2);
    check("not_done_yet", all_done, 0);
    reveal(2);
    check("all_done", all_done, 1);
    check("all_revealed", revealed, 9'h1FF);
    press(LF);
    no_req("done_left", 6);
    press(SEL);
    no_req("done_select", 6);
    check("done_held", all_done, 1);

    // Reset out of DONE, then abort an outstanding reveal request.
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    clear_model();
    check("rst2_revealed", revealed, 0);
    check("rst2_done", all_done, 0);
    grid_pulse();
    move(RT, 0, 1);
    press(SEL);
    n = 0;
    while (!draw_req && n < 20) begin tick(); n++; end
    check("abort_req_up", draw_req, 1);
    tick(); tick();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    clear_model();
    check("abort_req", draw_req, 0);
    check("abort_revealed", revealed, 0);
    check("abort_cursor", cursor_idx, 0);
    check("abort_col", draw_colour, 3'b111);
    press(RT);
    no_req("abort_wait_grid", 10);
    check("abort_wait_cursor", cursor_idx, 0);
    grid_pulse();
    move(RT, 0, 1);
    move(LF, 1, 0);   // card 1 erases blank: face store was cleared

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
